// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared core definitions: ALU control encodings, multiply/divide op encodings
// and the muldiv sequencer state type.
// -----------------------------------------------------------------------------
package core_pkg;

    // ALU control encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Multiply/divide op encodings (2'b11 is reserved and behaves as MUL)
    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MUL (low word) / DIVU / REMU built on the core's shared ALU, one
// add or subtract per iteration (shift-add multiply, restoring divide).
//
// Ports:
//   clk, rst            core clock, synchronous active-low reset
//   start, op           request (accepted in IDLE only) and operation select
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   kill                pipeline flush, aborts without a done pulse
//   busy, done          EX stall request, one-cycle result-valid pulse
//   result              product low / quotient / remainder, held until next start
//   alu_own             EX operand mux selects the sequencer's ALU inputs
//   alu_a/b/ctrl        ALU operands and control, zero outside RUN
//   alu_result          combinational ALU output
//
// Build option: define MULDIV_EARLY_OUT_EN to finish MUL as soon as the
// remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  acc_q, acc_d;    // MUL accumulator / DIV partial remainder
    logic [XLEN-1:0]  opa_q, opa_d;    // MUL multiplicand / DIV dividend->quotient
    logic [XLEN-1:0]  opb_q, opb_d;    // MUL multiplier / DIV divisor
    logic [XLEN-1:0]  result_q, result_d;

    logic            accept;
    logic            is_div_in;
    logic            is_div_q;
    logic            div_zero;
    logic            last_iter;
    logic            early_out;
    logic [XLEN:0]   trial;
    logic            trial_ge;

    assign accept    = (state_q == IDLE) && start && !kill;
    assign is_div_in = (op == MD_DIVU) || (op == MD_REMU);
    assign is_div_q  = (op_q == MD_DIVU) || (op_q == MD_REMU);
    assign div_zero  = is_div_in && (src_b == '0);
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !is_div_q && (opb_q == '0);
`else
    assign early_out = 1'b0;
`endif

    // Restoring-divide trial value; the compare is done locally at XLEN+1 bits
    // so the ALU carry flag is never needed.
    assign trial    = {acc_q, opa_q[XLEN-1]};
    assign trial_ge = (trial >= {1'b0, opb_q});

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (early_out || last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        alu_own  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        unique case (state_q)
            RUN: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                if (is_div_q) begin
                    alu_a    = trial[XLEN-1:0];
                    alu_b    = opb_q;
                    alu_ctrl = ALU_SUB;
                end else begin
                    alu_a = acc_q;
                    alu_b = opa_q;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = result_q;

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (accept) begin
            cnt_d = '0;
            op_d  = op;
            acc_d = '0;
            opa_d = src_a;
            opb_d = src_b;
            if (div_zero) begin
                result_d = (op == MD_DIVU) ? '1 : src_a;
            end
        end else if ((state_q == RUN) && !kill) begin
            if (early_out) begin
                result_d = acc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    // Remainder stays below the divisor, so XLEN bits hold it.
                    acc_d = trial_ge ? alu_result : trial[XLEN-1:0];
                    opa_d = {opa_q[XLEN-2:0], trial_ge};
                end else begin
                    if (opb_q[0]) begin
                        acc_d = alu_result;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (last_iter) begin
                    result_d = (op_q == MD_DIVU) ? opa_d : acc_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench: table of operations run back to back through the
// sequencer with a behavioural ALU, plus kill and reset corner sequences.
// Expected results/latencies go into a scoreboard queue at issue time and are
// popped when done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .kill       (kill),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Behavioural shared ALU
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        int bits;
`endif
        if (o == 2'b01 || o == 2'b10) return (b == 0) ? 1 : 33;
`ifdef MULDIV_EARLY_OUT_EN
        bits = 0;
        for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
        return (bits + 2 < 33) ? bits + 2 : 33;
`else
        return 33;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at the negedge of operation cycle cyc0; returns at the negedge of
    // the IDLE cycle after done.
    task automatic wait_done(input string name, input int cyc0);
        exp_t e;
        int   cyc;
        bit   seen;
        bit   run_ok;
        cyc    = cyc0;
        seen   = 1'b0;
        run_ok = 1'b1;
        while (cyc < 80) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy || !alu_own) run_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, "_run_busy"}, 32'(run_ok), 32'd1);
        e.res = '0;
        e.lat = 0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done by cycle %0d, required done at cycle %0d",
                     name, cyc, e.lat);
        end else begin
            check({name, "_latency"}, 32'(cyc), 32'(e.lat));
            check({name, "_result"}, result, e.res);
            check({name, "_done_ctl"}, {27'd0, busy, alu_own, alu_ctrl}, 32'h10);
            check({name, "_done_alu"}, alu_a | alu_b, 32'd0);
        end
        @(negedge clk);
        check({name, "_idle"}, {29'd0, busy, done, alu_own}, 32'd0);
        check({name, "_held"}, result, e.res);
    endtask

    // Entered at an IDLE-cycle negedge; start is driven in that cycle (cycle 0).
    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        op    = v.op;
        src_a = v.a;
        src_b = v.b;
        start = 1'b1;
        e.res = v.res;
        e.lat = exp_lat(v.op, v.b);
        sb_q.push_back(e);
        @(negedge clk);
        // Cycle 1: operands scrambled to show they were latched
        start = 1'b0;
        op    = ~v.op;
        src_a = ~v.a;
        src_b = ~v.b;
        if (e.lat > 1) begin
            if (v.op == 2'b01 || v.op == 2'b10) begin
                check({name, "_c1_alu_a"}, alu_a, {31'd0, v.a[31]});
                check({name, "_c1_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd1);
            end else begin
                check({name, "_c1_alu_a"}, alu_a, 32'd0);
                check({name, "_c1_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
            end
            check({name, "_c1_alu_b"}, alu_b, (v.op == 2'b01 || v.op == 2'b10) ? v.b : v.a);
        end
        wait_done(name, 1);
    endtask

    vec_t vecs[14];

    initial begin
        int          cyc;
        bit          saw_done;
        logic [31:0] prev_res;
        exp_t        e;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[2]  = '{2'b01, 32'd100,        32'd7,          32'd14};
        vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd2};
        vecs[4]  = '{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
        vecs[5]  = '{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678};
        vecs[6]  = '{2'b00, 32'd5,          32'd3,          32'd15};
        vecs[7]  = '{2'b11, 32'd9,          32'd4,          32'd36};
        vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF,  32'd10,         32'd5};
        vecs[10] = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[11] = '{2'b10, 32'h8000_0000,  32'h8000_0001,  32'h8000_0000};
        vecs[12] = '{2'b00, 32'h1234_5678,  32'd3,          32'h369D_0368};
        vecs[13] = '{2'b00, 32'h0000_1234,  32'd0,          32'd0};

        rst   = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {27'd0, busy, done, alu_own, alu_ctrl}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_alu", alu_a | alu_b, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table: each op starts in the IDLE cycle right after the previous DONE
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end
        prev_res = vecs[13].res;

        // kill together with start in IDLE: divide-by-zero would finish at once
        op    = 2'b01;
        src_a = 32'd5;
        src_b = 32'd0;
        start = 1'b1;
        kill  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        check("kill_start_c1", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        check("kill_start_c2", {30'd0, busy, done}, 32'd0);
        check("kill_start_result", result, prev_res);

        // kill mid-divide at cycle 10
        op       = 2'b01;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        saw_done = 1'b0;
        while (cyc < 10) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("kill_c10_busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_c11_idle", {29'd0, busy, done, alu_own}, 32'd0);
        check("kill_no_done", 32'(saw_done), 32'd0);
        check("kill_result_kept", result, prev_res);
        @(negedge clk);
        run_op('{2'b01, 32'd1000, 32'd3, 32'd333}, "after_kill");

        // Reset at cycle 20 of a MUL with start held through reset
        op    = 2'b00;
        src_a = 32'd7;
        src_b = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd11;
        src_b = 32'd13;
        @(negedge clk);
        check("midrst_ctl", {27'd0, busy, done, alu_own, alu_ctrl}, 32'd0);
        check("midrst_alu", alu_a | alu_b, 32'd0);
        check("midrst_result", result, 32'd0);
        rst   = 1'b1;
        e.res = 32'd143;
        e.lat = exp_lat(2'b00, 32'd13);
        sb_q.push_back(e);
        @(negedge clk);
        check("midrst_accept", {31'd0, busy}, 32'd1);
        // Divide-by-zero request while busy must be ignored
        op    = 2'b01;
        src_a = 32'd9;
        src_b = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrst_op", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for MUL (low 32 bits), DIVU and REMU. It reuses the core's shared 32-bit ALU, one add/sub per iteration, instead of instantiating a dedicated multiplier or divider. It sits beside the EX stage:
- It takes operands from the ID/EX register.
- While it owns the ALU, it drives the ALU operand/control inputs through the EX operand mux, selected by alu_own.
- It stalls the pipeline with busy until the result is written back.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-low reset; sampled on rising clk edge
start  in  1  request; accepted only in IDLE
op  in  2  00=MUL, 01=DIVU, 10=REMU, 11=reserved (treated as MUL)
src_a  in  XLEN  multiplicand / dividend
src_b  in  XLEN  multiplier / divisor
kill  in  1  pipeline flush; aborts any operation
busy  out  1  high in RUN and DONE; EX stall request
done  out  1  one-cycle pulse; result valid
result  out  XLEN  product low / quotient / remainder; held until next accepted start
alu_own  out  1  high in RUN; EX mux selects sequencer ALU inputs
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_ctrl  out  3  ALU control: 000=add, 001=sub
alu_result  in  XLEN  ALU Result, combinational from alu_a/alu_b/alu_ctrl

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=0 at clock edge):
  - State goes to IDLE; counter=0.
  - busy=0, done=0, result=0, alu_own=0, alu_a=0, alu_b=0, alu_ctrl=000.
  - Reset overrides every other input, including mid-operation.
- IDLE + start=1 (and kill=0):
  - Latch op, src_a, src_b; counter=0; next state RUN.
  - DIVU/REMU with src_b=0: go directly to DONE. Quotient=all ones, remainder=src_a.
- RUN: one iteration per cycle, exactly XLEN iterations; counter increments each cycle.
- MUL iteration:
  - Registers: acc (init 0), mcand (init src_a), mplier (init src_b).
  - alu_a=acc, alu_b=mcand, alu_ctrl=000.
  - If mplier[0]=1, acc<=alu_result.
  - mcand<=mcand<<1; mplier<=mplier>>1. Carry is discarded.
- DIVU/REMU iteration (restoring):
  - Registers: rem (XLEN+1 bits, init 0), quo (init src_a).
  - Form trial = {rem[XLEN-1:0], quo[XLEN-1]}.
  - alu_a=trial[XLEN-1:0], alu_b=divisor, alu_ctrl=001.
  - If trial >= divisor (local XLEN+1-bit compare): rem<=alu_result, shift 1 into quo.
  - Otherwise: rem<=trial, shift 0 into quo.
  - The ALU carry flag is not used.
- After iteration XLEN completes, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1; result loaded at entry (acc, quo or rem[XLEN-1:0]).
  - Next state IDLE.
- Outside RUN, alu_a/alu_b/alu_ctrl are driven to 0/0/000.
- Latency: start accepted at cycle 0 → done=1 at cycle XLEN+1 (33). Divide-by-zero → done at cycle 1.
- start while busy: ignored, no queuing.
- start in the IDLE cycle that immediately follows DONE: accepted.
- kill=1 in any state: next state IDLE, no done pulse, result unchanged.
- kill with start in the same cycle: kill wins; the request is not accepted.
- Operand changes after acceptance have no effect.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in RUN with op=MUL, if mplier==0 at the start of a cycle, go to DONE that cycle without iterating. Example: 5×3 gives done at cycle 4.
- Undefined: MUL always takes XLEN iterations; done at cycle 33.
- Division is unaffected in both builds.

Decomposition:
- Shared package core_pkg:
  - ALU control constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - Op encodings MD_MUL, MD_DIVU, MD_REMU.
  - State enum md_state_t {IDLE, RUN, DONE}.
- No sub-module; the iteration counter is inline.
- Benches instantiate the existing ALU block and connect alu_a/alu_b/alu_ctrl/alu_result to it.

Test Plan:
- MUL src_a=7, src_b=6, start at cycle 0 → busy=1 cycles 1–33; done pulse at cycle 33; result=42; alu_own=0 in cycle 34.
- MUL 0xFFFFFFFF×0xFFFFFFFF → result=0x00000001. DIVU 100/7 → result=14. REMU 100/7 → result=2. Each completes with done at cycle 33.
- DIVU 0x12345678/0 → done at cycle 1, result=0xFFFFFFFF. REMU same operands → result=0x12345678.
- Start DIVU 1000/3, then kill=1 at cycle 10 → IDLE at cycle 11, busy=0, no done pulse, result keeps its previous value. New start at cycle 12 is accepted.
- rst=0 at cycle 20 of a MUL, then start held high during and after reset → all outputs 0 at the next edge. The operation is accepted only on the first edge with rst=1. A start pulsed during busy is ignored, with done still at cycle 33 of the original operation.
- With MULDIV_EARLY_OUT_EN, 5×3 → done at cycle 4, result=15. Without the macro → done at cycle 33, result=15.
